// File: rtl/aes_pkg.sv
// Shared AES types, lookup tables and byte-level transforms.
// State bytes are indexed [row][col]; byte i of a 128-bit block lives at state[i%4][i/4].
package aes_pkg;

    typedef logic [7:0]       byte_t;
    typedef byte_t [0:3][0:3] state_t;
    typedef logic [31:0]      word_t;

    localparam int AES128_NR = 10;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [0:3][7:0] IMC_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    function automatic byte_t rcon_of(input logic [3:0] idx);
        byte_t rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic state_t to_state(input logic [127:0] b);
        state_t s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = b[127 - 8 * (4 * c + r) -: 8];
            end
        end
        return s;
    endfunction

    function automatic logic [127:0] from_state(input state_t s);
        logic [127:0] b;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[127 - 8 * (4 * c + r) -: 8] = s[r][c];
            end
        end
        return b;
    endfunction

    function automatic byte_t gf_mul2(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = gf_mul2(x);
        end
        return p;
    endfunction

    function automatic state_t add_round_key(input state_t s, input state_t k);
        state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r][c] = s[r][c] ^ k[r][c];
            end
        end
        return o;
    endfunction

    // Row r rotates right by r positions.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r][c] = s[r][(c - r + 4) % 4];
            end
        end
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r][c] = INV_SBOX[s[r][c]];
            end
        end
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[r][c] = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    o[r][c] = o[r][c] ^ gf_mul(IMC_COEF[(j - r + 4) % 4], s[j][c]);
                end
            end
        end
        return o;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Undo one key-schedule step: recover round key r-1 from round key r.
    function automatic logic [127:0] inv_expand(input logic [127:0] k, input byte_t rc);
        word_t w0, w1, w2, w3;
        word_t w3_p, w2_p, w1_p, w0_p;
        {w0, w1, w2, w3} = k;
        w3_p = w3 ^ w2;
        w2_p = w2 ^ w1;
        w1_p = w1 ^ w0;
        w0_p = w0 ^ sub_word({w3_p[23:0], w3_p[31:24]}) ^ {rc, 24'h000000};
        return {w0_p, w1_p, w2_p, w3_p};
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_inv_round.sv
// One combinational AES inverse round; the mix step is bypassed for the final round.
module inv_round
    import aes_pkg::*;
(
    input  state_t st_in,
    input  state_t round_key,
    input  logic   bypass_mix,
    output state_t st_out
);

    state_t keyed_s;

    // Inverse round datapath.
    always_comb begin
        keyed_s = add_round_key(inv_sub_bytes(inv_shift_rows(st_in)), round_key);
        if (bypass_mix) begin
            st_out = keyed_s;
        end else begin
            st_out = inv_mix_columns(keyed_s);
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys
// regenerated backwards from the last expanded key.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR           = 10,
    parameter bit BACK_TO_BACK = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] last_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    if (NR != AES128_NR) begin : g_nr_check
        $error("aes_inv_cipher_iter: only NR=10 (AES-128) is supported");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] FIRST_RND = 4'(NR - 1);

    fsm_t         state_r, state_s;
    logic [3:0]   rnd_r, rnd_s;
    state_t       st_r, st_s, load_st_s, round_out_s, round_key_st_s;
    logic [127:0] key_r, key_s, round_key_s;
    logic [127:0] plaintext_r, pt_s;
    logic         out_valid_r, busy_r;
    logic         in_ready_s, accept_s, is_last_s;

    // Input handshake; in DONE the back-to-back variant lets out_ready open the input.
    always_comb begin
        in_ready_s = 1'b0;
        if (!rst_n) begin
            in_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (BACK_TO_BACK && (state_r == DONE)) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid & in_ready_s;
    end

    // Key for the current round; rnd reaches 0 in LAST so rcon[rnd+1] also yields key 0.
    always_comb begin
        round_key_s    = inv_expand(key_r, rcon_of(rnd_r + 4'd1));
        round_key_st_s = to_state(round_key_s);
        load_st_s      = add_round_key(to_state(ciphertext), to_state(last_key));
        is_last_s      = (state_r == LAST);
    end

    inv_round u_inv_round (
        .st_in      (st_r),
        .round_key  (round_key_st_s),
        .bypass_mix (is_last_s),
        .st_out     (round_out_s)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_s = state_r;
        rnd_s   = rnd_r;
        st_s    = st_r;
        key_s   = key_r;
        pt_s    = plaintext_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ROUND;
                    st_s    = load_st_s;
                    key_s   = last_key;
                    rnd_s   = FIRST_RND;
                end else begin
                    state_s = IDLE;
                end
            end
            ROUND: begin
                st_s  = round_out_s;
                key_s = round_key_s;
                rnd_s = rnd_r - 4'd1;
                if (rnd_r == 4'd1) begin
                    state_s = LAST;
                end else begin
                    state_s = ROUND;
                end
            end
            LAST: begin
                pt_s    = from_state(round_out_s);
                state_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept_s) begin
                        state_s = ROUND;
                        st_s    = load_st_s;
                        key_s   = last_key;
                        rnd_s   = FIRST_RND;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rnd_r       <= 4'd0;
            st_r        <= 128'h0;
            key_r       <= 128'h0;
            plaintext_r <= 128'h0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rnd_r       <= rnd_s;
            st_r        <= st_s;
            key_r       <= key_s;
            plaintext_r <= pt_s;
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s == ROUND) || (state_s == LAST);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign plaintext = plaintext_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboarded bench for the iterative AES-128 decryptor; expected plaintexts
// come from FIPS-197 vectors and an independent encrypt model.
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] A1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] A1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] ciphertext, last_key, plaintext;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_ciphertext, b_last_key, b_plaintext;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [127:0] exp_q[$];
    logic [127:0] b_exp_q[$];
    logic [7:0]   sbox_m [256];

    aes_inv_cipher_iter #(.NR(10), .BACK_TO_BACK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ciphertext(ciphertext), .last_key(last_key), .out_valid(out_valid),
        .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
    );

    aes_inv_cipher_iter #(.NR(10), .BACK_TO_BACK(1'b1)) dut_b2b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .ciphertext(b_ciphertext), .last_key(b_last_key), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .plaintext(b_plaintext), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic encrypt(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  st [16];
        logic [7:0]  tmp [16];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox_m[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r + 4 * c] = tmp[r + 4 * ((c + r) % 4)];
            if (rd != 10) begin
                for (int i = 0; i < 16; i++) tmp[i] = st[i];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        st[4 * c + r] = xt(tmp[4 * c + r]) ^ xt(tmp[4 * c + (r + 1) % 4]) ^ tmp[4 * c + (r + 1) % 4]
                                      ^ tmp[4 * c + (r + 2) % 4] ^ tmp[4 * c + (r + 3) % 4];
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4 * rd + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = st[i];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // Offer a block, wait for acceptance, push its expected plaintext.
    task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                        output int acc_cyc);
        int n = 0;
        in_valid = 1'b1;
        ciphertext = ct;
        last_key = key;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(pt);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, compare against the scoreboard head, complete the handshake.
    task automatic receive(input string tag, input int acc_cyc, input bit chk_lat);
        int n = 0;
        logic [127:0] exp;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
        if (chk_lat) check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'd10);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = {128{1'bx}};
        check({tag, "_pt"}, plaintext, exp);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, acc2, hs, n;
        logic [127:0] ct_m, k10_m, key_r, pt_r;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; ciphertext = 128'h0; last_key = 128'h0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_ciphertext = 128'h0; b_last_key = 128'h0;
        for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_plaintext", plaintext, 128'd0);
        check("rst_b2b_in_ready", {127'd0, b_in_ready}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {127'd0, in_ready}, 128'd1);

        // Reference model against published vectors
        encrypt(C1_PT, C1_KEY, ct_m, k10_m);
        check("model_c1_ct", ct_m, C1_CT);
        check("model_c1_k10", k10_m, C1_K10);
        encrypt(A1_PT, A1_KEY, ct_m, k10_m);
        check("model_a1_ct", ct_m, A1_CT);
        check("model_a1_k10", k10_m, A1_K10);

        // FIPS-197 C.1 with latency and busy checks
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(C1_CT, C1_K10, C1_PT, acc);
        repeat (3) @(negedge clk);
        check("c1_busy", {127'd0, busy}, 128'd1);
        check("c1_in_ready_busy", {127'd0, in_ready}, 128'd0);
        receive("c1", acc, 1'b1);

        // FIPS-197 A.1/B
        send(A1_CT, A1_K10, A1_PT, acc);
        receive("a1", acc, 1'b1);

        // Backpressure: output held 20 cycles while the next block is offered
        out_ready = 1'b0;
        send(C1_CT, C1_K10, C1_PT, acc);
        in_valid = 1'b1;
        ciphertext = A1_CT;
        last_key = A1_K10;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {127'd0, out_valid}, 128'd1);
            check("bp_hold_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_hold_pt", plaintext, (exp_q.size() > 0) ? exp_q[0] : {128{1'bx}});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        receive("bp", acc, 1'b0);
        hs = cyc;
        send(A1_CT, A1_K10, A1_PT, acc);
        check("bp_accept_after_hs", 128'(acc - hs), 128'd1);
        receive("bp_next", acc, 1'b1);

        // Reset in the middle of a block discards it
        send(C1_CT, C1_K10, C1_PT, acc);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        send(C1_CT, C1_K10, C1_PT, acc);
        receive("midrst_c1", acc, 1'b1);

        // Random blocks, with junk offered on odd iterations while busy
        for (int it = 0; it < 1000; it++) begin
            key_r = {$urandom, $urandom, $urandom, $urandom};
            pt_r = {$urandom, $urandom, $urandom, $urandom};
            encrypt(pt_r, key_r, ct_m, k10_m);
            send(ct_m, k10_m, pt_r, acc);
            if (it % 2 == 1) begin
                in_valid = 1'b1;
                ciphertext = {$urandom, $urandom, $urandom, $urandom};
                last_key = {$urandom, $urandom, $urandom, $urandom};
            end
            receive("rand", acc, 1'b1);
        end
        in_valid = 1'b0;

        // Back-to-back variant with in_valid held across both vectors
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        b_ciphertext = C1_CT;
        b_last_key = C1_K10;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        b_exp_q.push_back(C1_PT);
        b_ciphertext = A1_CT;
        b_last_key = A1_K10;
        n = 0;
        @(negedge clk);
        while (!b_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 128'(cyc - acc), 128'd10);
        check("b2b_in_ready_done", {127'd0, b_in_ready}, 128'd1);
        check("b2b_first_pt", b_plaintext, (b_exp_q.size() > 0) ? b_exp_q.pop_front() : {128{1'bx}});
        @(posedge clk);
        #1;
        acc2 = cyc;
        b_exp_q.push_back(A1_PT);
        b_in_valid = 1'b0;
        check("b2b_spacing", 128'(acc2 - acc), 128'd11);
        n = 0;
        @(negedge clk);
        while (!b_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_latency", 128'(cyc - acc2), 128'd10);
        check("b2b_second_pt", b_plaintext, (b_exp_q.size() > 0) ? b_exp_q.pop_front() : {128{1'bx}});
        @(posedge clk);
        #1;

        check("sb_empty", 128'(exp_q.size() + b_exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
